pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter FWD_EN, default 1; 1 = forwarding mode, 0 = stall-until-writeback mode.
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: ports clk and reset.
REQ-005 Ports, in order:
clk  in  1  clock
reset  in  1  async active-low reset
ext_stall  in  1  freeze whole pipeline, e.g. RAM wait
id_rs, id_rt  in  REG_ADDR_W each  source registers of the instruction in ID
id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source
ex_rs, ex_rt  in  REG_ADDR_W each  sources of the instruction in EX
ex_rd  in  REG_ADDR_W  EX destination (after the regDst mux)
ex_regWrite, ex_memRead  in  1 each  EX control bits
mem_rd  in  REG_ADDR_W  MEM destination
mem_regWrite  in  1  MEM control bit
mem_redirect  in  1  branch taken or jump resolved in MEM
wb_rd  in  REG_ADDR_W  WB destination
wb_regWrite  in  1  WB control bit
pc_en, if_id_en  out  1 each  load enables
id_ex_bubble  out  1  zero control bits into ID/EX
flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear stage
fwd_a_sel, fwd_b_sel  out  2 each  ALU operand source
stall_count, flush_count  out  CNT_W each  saturating statistics

Function
REQ-006 SHALL keep valid bits v_if_id, v_id_ex, v_ex_mem, v_mem_wb; a destination or redirect counts only when its stage bit is 1.
REQ-007 On each clock with ext_stall=0, SHALL update: v_mem_wb<=v_ex_mem; v_ex_mem<=v_id_ex & ~flush; v_id_ex<=v_if_id & ~stall & ~flush; v_if_id<=~flush, or hold v_if_id when stall=1.
REQ-008 With ext_stall=1, SHALL hold all valid bits and counters; outputs pc_en=0, if_id_en=0; all flush and bubble outputs 0.
REQ-009 flush = mem_redirect & v_ex_mem; asserts flush_if_id, flush_id_ex and flush_ex_mem together, with pc_en=1 and if_id_en=1, in the same cycle.
REQ-010 FWD_EN=1: stall = v_id_ex & ex_memRead & ex_regWrite & ex_rd!=0 & v_if_id & (id_uses_rs & id_rs==ex_rd | id_uses_rt & id_rt==ex_rd).
REQ-011 FWD_EN=0: stall is 1 when a used ID source (nonzero) equals a nonzero destination with regWrite=1 in a valid ID/EX or EX/MEM stage.
REQ-012 stall SHALL drive pc_en=0, if_id_en=0, id_ex_bubble=1.
REQ-013 Priority: ext_stall > flush > stall; stall is ignored in a flush cycle.
REQ-014 Forwarding, FWD_EN=1, per operand: 2'b10 if v_ex_mem & mem_regWrite & mem_rd!=0 & mem_rd==src; else 2'b01 if v_mem_wb & wb_regWrite & wb_rd!=0 & wb_rd==src; else 2'b00. The EX/MEM source wins over MEM/WB.
REQ-015 FWD_EN=0: fwd_a_sel and fwd_b_sel SHALL be constant 2'b00.
REQ-016 stall_count increments on each clock with stall=1 and ext_stall=0 and no flush; flush_count increments on each clock with flush=1 and ext_stall=0; both saturate at all-ones.
REQ-017 Hazard, flush and forwarding outputs are combinational from inputs and valid bits; there is zero-cycle latency from an input change to these outputs.

Reset
REQ-018 reset=0 SHALL asynchronously clear all valid bits and both counters.
REQ-019 While in reset: pc_en=1, if_id_en=1, id_ex_bubble=0, all flushes 0, fwd selects 2'b00.
REQ-020 Reset asserted mid-stall or mid-flush SHALL abandon that stall or flush; no stall or flush is asserted in the first cycle after release.

Structure
REQ-021 pipeline_pkg SHALL hold the fwd select constants FWD_RF=2'b00, FWD_MEM_WB=2'b01 and FWD_EX_MEM=2'b10.
REQ-022 SHALL instantiate sub-module forward_sel twice, once per ALU operand.

Verification
REQ-023 Load-use case: EX lw ex_rd=8 with ex_memRead=1, ID add id_rs=8 -> exactly one cycle with pc_en=0 and id_ex_bubble=1; the next cycle gives fwd_a_sel=2'b01; stall_count=1.
REQ-024 Double-hit case: mem_rd=9 and wb_rd=9, both writing, ex_rs=9 -> fwd_a_sel=2'b10. Zero-register case: ex_rs=0 with mem_rd=0 -> 2'b00.
REQ-025 Redirect case: mem_redirect=1 with v_ex_mem=1 coinciding with a load-use stall -> all three flushes=1, pc_en=1, no bubble; flush_count=1; the next cycle gives v_id_ex=0 and v_ex_mem=0.
REQ-026 Freeze case: ext_stall=1 for 3 cycles during a pending load-use -> valid bits and counters unchanged, pc_en=0; the stall resolves after release.
REQ-027 FWD_EN=0 case: add r3 in EX followed by sub using r3 in ID -> 2 stall cycles, fwd selects 2'b00 throughout.
REQ-028 Reset case: reset=0 mid-flush, then release -> counters 0, v_* 0, pc_en=1; with CNT_W=2 and 5 stalls, stall_count saturates at 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline hazard controller: ALU operand source selects.
package pipeline_pkg;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_MEM_WB = 2'b01;
   localparam logic [1:0] FWD_EX_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Per-operand forwarding mux select; the younger EX/MEM result wins over MEM/WB.
module forward_sel
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int FWD_EN     = 1
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  v_ex_mem,
   input  logic                  mem_regWrite,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  v_mem_wb,
   input  logic                  wb_regWrite,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output logic [1:0]            sel
);

   logic       mem_hit_s;
   logic       wb_hit_s;
   logic [1:0] sel_s;

   assign mem_hit_s = v_ex_mem & mem_regWrite & (mem_rd != {REG_ADDR_W{1'b0}}) & (mem_rd == src);
   assign wb_hit_s  = v_mem_wb & wb_regWrite & (wb_rd != {REG_ADDR_W{1'b0}}) & (wb_rd == src);

   // Operand source priority: EX/MEM, then MEM/WB, else register file
   always_comb begin
      sel_s = FWD_RF;
      if (FWD_EN == 0) begin
         sel_s = FWD_RF;
      end else if (mem_hit_s) begin
         sel_s = FWD_EX_MEM;
      end else if (wb_hit_s) begin
         sel_s = FWD_MEM_WB;
      end else begin
         sel_s = FWD_RF;
      end
   end

   assign sel = sel_s;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use / RAW stalls, redirect flushes,
// operand forwarding selects and saturating stall/flush statistics.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ext_stall,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_regWrite,
   input  logic                  ex_memRead,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_regWrite,
   input  logic                  mem_redirect,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_regWrite,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_bubble,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  flush_ex_mem,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count
);

   logic             v_if_id_r;
   logic             v_id_ex_r;
   logic             v_ex_mem_r;
   logic             v_mem_wb_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   logic flush_s;
   logic stall_raw_s;
   logic stall_s;
   logic pc_en_s;
   logic if_id_en_s;
   logic bubble_s;
   logic flush_out_s;

   // A used, nonzero source matching a valid stage that will write it
   function automatic logic src_hit(input logic uses, input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] dst, input logic wr,
                                    input logic v);
      return uses & v & wr & (src != {REG_ADDR_W{1'b0}}) & (src == dst);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1'b1);
   endfunction

   assign flush_s = mem_redirect & v_ex_mem_r;
   assign stall_s = stall_raw_s & ~flush_s;

   // Stall detection: load-use only when forwarding, any in-flight RAW otherwise
   always_comb begin
      stall_raw_s = 1'b0;
      if (FWD_EN != 0) begin
         stall_raw_s = v_if_id_r & v_id_ex_r & ex_memRead &
                       (src_hit(id_uses_rs, id_rs, ex_rd, ex_regWrite, 1'b1) |
                        src_hit(id_uses_rt, id_rt, ex_rd, ex_regWrite, 1'b1));
      end else begin
         stall_raw_s = v_if_id_r &
                       (src_hit(id_uses_rs, id_rs, ex_rd,  ex_regWrite,  v_id_ex_r)  |
                        src_hit(id_uses_rt, id_rt, ex_rd,  ex_regWrite,  v_id_ex_r)  |
                        src_hit(id_uses_rs, id_rs, mem_rd, mem_regWrite, v_ex_mem_r) |
                        src_hit(id_uses_rt, id_rt, mem_rd, mem_regWrite, v_ex_mem_r));
      end
   end

   // Pipeline control outputs: reset, then ext_stall > flush > stall
   always_comb begin
      pc_en_s     = 1'b1;
      if_id_en_s  = 1'b1;
      bubble_s    = 1'b0;
      flush_out_s = 1'b0;
      if (!reset) begin
         pc_en_s    = 1'b1;
         if_id_en_s = 1'b1;
      end else if (ext_stall) begin
         pc_en_s    = 1'b0;
         if_id_en_s = 1'b0;
      end else if (flush_s) begin
         flush_out_s = 1'b1;
      end else if (stall_raw_s) begin
         pc_en_s    = 1'b0;
         if_id_en_s = 1'b0;
         bubble_s   = 1'b1;
      end else begin
         pc_en_s    = 1'b1;
         if_id_en_s = 1'b1;
      end
   end

   assign pc_en        = pc_en_s;
   assign if_id_en     = if_id_en_s;
   assign id_ex_bubble = bubble_s;
   assign flush_if_id  = flush_out_s;
   assign flush_id_ex  = flush_out_s;
   assign flush_ex_mem = flush_out_s;

   // Stage valid bits advance with the pipeline unless frozen
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_if_id_r  <= 1'b0;
         v_id_ex_r  <= 1'b0;
         v_ex_mem_r <= 1'b0;
         v_mem_wb_r <= 1'b0;
      end else if (!ext_stall) begin
         v_mem_wb_r <= v_ex_mem_r;
         v_ex_mem_r <= v_id_ex_r & ~flush_s;
         v_id_ex_r  <= v_if_id_r & ~stall_s & ~flush_s;
         v_if_id_r  <= stall_s ? v_if_id_r : ~flush_s;
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else if (!ext_stall) begin
         if (stall_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end
         if (flush_s) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
         end
      end
   end

   assign stall_count = stall_cnt_r;
   assign flush_count = flush_cnt_r;

   forward_sel #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd_a (
      .src          (ex_rs),
      .v_ex_mem     (v_ex_mem_r),
      .mem_regWrite (mem_regWrite),
      .mem_rd       (mem_rd),
      .v_mem_wb     (v_mem_wb_r),
      .wb_regWrite  (wb_regWrite),
      .wb_rd        (wb_rd),
      .sel          (fwd_a_sel)
   );

   forward_sel #(.REG_ADDR_W(REG_ADDR_W), .FWD_EN(FWD_EN)) u_fwd_b (
      .src          (ex_rt),
      .v_ex_mem     (v_ex_mem_r),
      .mem_regWrite (mem_regWrite),
      .mem_rd       (mem_rd),
      .v_mem_wb     (v_mem_wb_r),
      .wb_regWrite  (wb_regWrite),
      .wb_rd        (wb_rd),
      .sel          (fwd_b_sel)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: instance a uses forwarding, instance b is stall-until-writeback with 2-bit counters.
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       rst_a, rst_b;
   logic       ext_stall;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic       id_uses_rs, id_uses_rt, ex_regWrite, ex_memRead;
   logic       mem_regWrite, mem_redirect, wb_regWrite;

   logic        a_pc_en, a_if_id_en, a_bubble, a_fl_if, a_fl_id, a_fl_ex;
   logic [1:0]  a_fwd_a, a_fwd_b;
   logic [15:0] a_stall_cnt, a_flush_cnt;
   logic        b_pc_en, b_if_id_en, b_bubble, b_fl_if, b_fl_id, b_fl_ex;
   logic [1:0]  b_fwd_a, b_fwd_b;
   logic [1:0]  b_stall_cnt, b_flush_cnt;

   logic [5:0] ctl_a, ctl_b;
   logic [3:0] va, vb;

   int n_chk  = 0;
   int n_fail = 0;

   assign ctl_a = {a_pc_en, a_if_id_en, a_bubble, a_fl_if, a_fl_id, a_fl_ex};
   assign ctl_b = {b_pc_en, b_if_id_en, b_bubble, b_fl_if, b_fl_id, b_fl_ex};
   assign va = {dut_a.v_if_id_r, dut_a.v_id_ex_r, dut_a.v_ex_mem_r, dut_a.v_mem_wb_r};
   assign vb = {dut_b.v_if_id_r, dut_b.v_id_ex_r, dut_b.v_ex_mem_r, dut_b.v_mem_wb_r};

   pipeline_hazard_ctrl dut_a (
      .clk(clk), .reset(rst_a), .ext_stall(ext_stall),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
      .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .mem_redirect(mem_redirect),
      .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
      .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_bubble(a_bubble),
      .flush_if_id(a_fl_if), .flush_id_ex(a_fl_id), .flush_ex_mem(a_fl_ex),
      .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b),
      .stall_count(a_stall_cnt), .flush_count(a_flush_cnt)
   );

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(0), .CNT_W(2)) dut_b (
      .clk(clk), .reset(rst_b), .ext_stall(ext_stall),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
      .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .mem_redirect(mem_redirect),
      .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
      .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_bubble(b_bubble),
      .flush_if_id(b_fl_if), .flush_id_ex(b_fl_id), .flush_ex_mem(b_fl_ex),
      .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b),
      .stall_count(b_stall_cnt), .flush_count(b_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      ext_stall = 1'b0; mem_redirect = 1'b0;
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_regWrite = 1'b0; ex_memRead = 1'b0;
      mem_rd = 5'd0; mem_regWrite = 1'b0; wb_rd = 5'd0; wb_regWrite = 1'b0;
   endtask

   task automatic load_use_r8();
      ex_rd = 5'd8; ex_memRead = 1'b1; ex_regWrite = 1'b1;
      id_rs = 5'd8; id_uses_rs = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      rst_a = 1'b1; rst_b = 1'b1;
      #1; rst_a = 1'b0; rst_b = 1'b0;
      #2;
      chk("reset_ctl_a", 32'(ctl_a), 32'b110000);
      chk("reset_fwd_a", 32'({a_fwd_a, a_fwd_b}), 32'd0);
      chk("reset_cnt_a", 32'({a_stall_cnt, a_flush_cnt}), 32'd0);
      chk("reset_v_a", 32'(va), 32'd0);
      chk("reset_ctl_b", 32'(ctl_b), 32'b110000);
      ext_stall = 1'b1; #1;
      chk("reset_ext_stall_ctl_a", 32'(ctl_a), 32'b110000);
      ext_stall = 1'b0;

      // Release with a load-use pattern present: valid bits are clear, so no stall
      load_use_r8();
      @(negedge clk) rst_a = 1'b1;
      #1;
      chk("post_reset_no_stall", 32'(ctl_a), 32'b110000);
      clear_inputs();
      repeat (4) tick();
      chk("fill_v_a", 32'(va), 32'b1111);

      // Load-use stall
      load_use_r8(); #1;
      chk("lu_stall_ctl", 32'(ctl_a), 32'b001000);
      tick();
      chk("lu_v_after", 32'(va), 32'b1011);
      chk("lu_stall_cnt", 32'(a_stall_cnt), 32'd1);
      ex_regWrite = 1'b1; ex_memRead = 1'b1; #1;
      chk("lu_no_second_stall", 32'(ctl_a), 32'b110000);
      tick();
      clear_inputs();
      ex_rs = 5'd8; ex_rd = 5'd10; ex_regWrite = 1'b1;
      mem_rd = 5'd8; mem_regWrite = 1'b1; wb_rd = 5'd8; wb_regWrite = 1'b1; #1;
      chk("lu_fwd_wb", 32'(a_fwd_a), 32'b01);
      chk("lu_stall_cnt_hold", 32'(a_stall_cnt), 32'd1);
      tick();
      clear_inputs();
      tick();
      chk("fwd_v_full", 32'(va), 32'b1111);

      // Forwarding priority and zero register
      ex_rs = 5'd9; ex_rt = 5'd7; mem_rd = 5'd9; mem_regWrite = 1'b1;
      wb_rd = 5'd7; wb_regWrite = 1'b1; #1;
      chk("fwd_a_exmem", 32'(a_fwd_a), 32'b10);
      chk("fwd_b_memwb", 32'(a_fwd_b), 32'b01);
      wb_rd = 5'd9; #1;
      chk("fwd_double_hit", 32'(a_fwd_a), 32'b10);
      chk("fwd_b_none", 32'(a_fwd_b), 32'b00);
      mem_regWrite = 1'b0; #1;
      chk("fwd_mem_nowrite", 32'(a_fwd_a), 32'b01);
      ex_rs = 5'd0; mem_rd = 5'd0; mem_regWrite = 1'b1; wb_rd = 5'd0; #1;
      chk("fwd_zero_reg", 32'(a_fwd_a), 32'b00);
      clear_inputs();

      // Redirect coinciding with load-use
      load_use_r8(); mem_redirect = 1'b1; #1;
      chk("redir_ctl", 32'(ctl_a), 32'b110111);
      tick();
      chk("redir_flush_cnt", 32'(a_flush_cnt), 32'd1);
      chk("redir_stall_cnt", 32'(a_stall_cnt), 32'd1);
      chk("redir_v_after", 32'(va), 32'b0001);
      chk("redir_gated", 32'(ctl_a), 32'b110000);
      clear_inputs();
      tick(); tick();
      chk("refill_v", 32'(va), 32'b1100);

      // Freeze during a pending load-use
      load_use_r8(); ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("freeze_ctl", 32'(ctl_a), 32'b000000);
         tick();
         chk("freeze_v", 32'(va), 32'b1100);
         chk("freeze_cnt", 32'({a_stall_cnt, a_flush_cnt}), 32'h0001_0001);
      end
      ext_stall = 1'b0; #1;
      chk("unfreeze_stall", 32'(ctl_a), 32'b001000);
      tick();
      chk("unfreeze_stall_cnt", 32'(a_stall_cnt), 32'd2);
      chk("unfreeze_v", 32'(va), 32'b1010);
      chk("unfreeze_resolved", 32'(ctl_a), 32'b110000);

      // Reset in the middle of a flush
      mem_redirect = 1'b1; #1;
      chk("midflush_ctl", 32'(ctl_a), 32'b110111);
      rst_a = 1'b0; #1;
      chk("midflush_rst_ctl", 32'(ctl_a), 32'b110000);
      chk("midflush_rst_cnt", 32'({a_stall_cnt, a_flush_cnt}), 32'd0);
      chk("midflush_rst_v", 32'(va), 32'd0);
      @(negedge clk) rst_a = 1'b1;
      #1;
      chk("midflush_release_ctl", 32'(ctl_a), 32'b110000);
      tick();
      chk("midflush_release_cnt", 32'(a_flush_cnt), 32'd0);

      // Stall-until-writeback instance
      clear_inputs();
      @(negedge clk) rst_b = 1'b1;
      repeat (4) tick();
      chk("b_fill_v", 32'(vb), 32'b1111);
      ex_rd = 5'd3; ex_regWrite = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
      ex_rs = 5'd3; ex_rt = 5'd3; #1;
      chk("b_raw_ex_stall", 32'(ctl_b), 32'b001000);
      chk("b_fwd_const_1", 32'({b_fwd_a, b_fwd_b}), 32'd0);
      tick();
      ex_rd = 5'd0; ex_regWrite = 1'b0; mem_rd = 5'd3; mem_regWrite = 1'b1; #1;
      chk("b_raw_mem_stall", 32'(ctl_b), 32'b001000);
      chk("b_fwd_const_2", 32'({b_fwd_a, b_fwd_b}), 32'd0);
      chk("b_stall_cnt_1", 32'(b_stall_cnt), 32'd1);
      tick();
      mem_rd = 5'd0; mem_regWrite = 1'b0; wb_rd = 5'd3; wb_regWrite = 1'b1; #1;
      chk("b_raw_wb_no_stall", 32'(ctl_b), 32'b110000);
      chk("b_fwd_const_3", 32'({b_fwd_a, b_fwd_b}), 32'd0);
      chk("b_stall_cnt_2", 32'(b_stall_cnt), 32'd2);
      tick();
      clear_inputs();
      ex_rd = 5'd4; ex_regWrite = 1'b1; id_rt = 5'd4; id_uses_rt = 1'b1; #1;
      chk("b_rt_stall", 32'(ctl_b), 32'b001000);
      tick();
      chk("b_stall_cnt_3", 32'(b_stall_cnt), 32'd3);
      ex_rd = 5'd0; ex_regWrite = 1'b0; mem_rd = 5'd4; mem_regWrite = 1'b1; #1;
      chk("b_rt_mem_stall", 32'(ctl_b), 32'b001000);
      tick();
      chk("b_stall_cnt_sat_4", 32'(b_stall_cnt), 32'd3);
      clear_inputs();
      tick();
      ex_rd = 5'd0; ex_regWrite = 1'b1; id_rs = 5'd0; id_uses_rs = 1'b1; #1;
      chk("b_zero_reg_no_stall", 32'(ctl_b), 32'b110000);
      ex_rd = 5'd5; id_rs = 5'd5; #1;
      chk("b_fifth_stall", 32'(ctl_b), 32'b001000);
      tick();
      chk("b_stall_cnt_sat_5", 32'(b_stall_cnt), 32'd3);
      chk("b_flush_cnt", 32'(b_flush_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
